// File: rtl/puzzle_gauntlet.sv
// Multi-round alarm puzzle: presents NUM_ROUNDS LFSR targets, counts correct answers and strikes.
// Optional build macro PUZZLE_STRIKE_RESET_EN: a strike clears round_Cnt back to 0.
module puzzle_gauntlet #(
  parameter int          NUM_ROUNDS    = 4,
  parameter int          SW_W          = 4,
  parameter int          TIMEOUT_TICKS = 10,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              alm_Sound,
  input  logic [SW_W-1:0]                   sw,
  input  logic                              btn_Confirm,
  input  logic                              tick_1Hz,
  output logic                              ext_Disp_On,
  output logic [SW_W-1:0]                   hex_Num,
  output logic [$clog2(NUM_ROUNDS+1)-1:0]   round_Cnt,
  output logic                              fail_Pulse,
  output logic                              puzzle_Solved
);

  localparam int          RW   = $clog2(NUM_ROUNDS + 1);
  localparam int          TW   = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, SOLVED} state_t;

  state_t          state, state_n;
  logic [15:0]     lfsr, lfsr_n;
  logic [TW-1:0]   timer, timer_n;
  logic            btn_prev;
  logic            confirm;
  logic            strike;
  logic            disp_n;
  logic [SW_W-1:0] hex_n;
  logic [RW-1:0]   rc_n;
  logic            fail_n;
  logic            solved_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      lfsr          <= SEED;
      timer         <= '0;
      btn_prev      <= 1'b0;
      ext_Disp_On   <= 1'b0;
      hex_Num       <= '0;
      round_Cnt     <= '0;
      fail_Pulse    <= 1'b0;
      puzzle_Solved <= 1'b0;
    end else begin
      state         <= state_n;
      lfsr          <= lfsr_n;
      timer         <= timer_n;
      btn_prev      <= btn_Confirm;
      ext_Disp_On   <= disp_n;
      hex_Num       <= hex_n;
      round_Cnt     <= rc_n;
      fail_Pulse    <= fail_n;
      puzzle_Solved <= solved_n;
    end
  end

  assign confirm = btn_Confirm & ~btn_prev;

  always_comb begin
    state_n  = state;
    lfsr_n   = lfsr;
    timer_n  = timer;
    disp_n   = ext_Disp_On;
    hex_n    = hex_Num;
    rc_n     = round_Cnt;
    fail_n   = 1'b0;
    solved_n = puzzle_Solved;
    strike   = 1'b0;

    // Galois right-shift form of x^16+x^14+x^13+x^11+1
    if (alm_Sound && state != SOLVED)
      lfsr_n = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

    if (!alm_Sound) begin
      state_n  = IDLE;
      timer_n  = '0;
      disp_n   = 1'b0;
      hex_n    = '0;
      rc_n     = '0;
      solved_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_n  = LOAD;
          timer_n  = '0;
          disp_n   = 1'b0;
          hex_n    = '0;
          rc_n     = '0;
          solved_n = 1'b0;
        end
        LOAD: begin
          hex_n   = lfsr[SW_W-1:0];
          timer_n = '0;
          disp_n  = 1'b1;
          state_n = WAIT;
        end
        WAIT: begin
          // a confirm in the same cycle as a tick wins; the tick is dropped
          if (confirm) begin
            if (sw == hex_Num) begin
              if (round_Cnt == RW'(NUM_ROUNDS - 1)) begin
                rc_n     = RW'(NUM_ROUNDS);
                solved_n = 1'b1;
                disp_n   = 1'b0;
                state_n  = SOLVED;
              end else begin
                rc_n    = round_Cnt + 1'b1;
                state_n = LOAD;
              end
            end else begin
              strike = 1'b1;
            end
          end else if (tick_1Hz) begin
            if (timer == TW'(TIMEOUT_TICKS - 1))
              strike = 1'b1;
            else
              timer_n = timer + 1'b1;
          end
          if (strike) begin
            fail_n  = 1'b1;
            state_n = LOAD;
`ifdef PUZZLE_STRIKE_RESET_EN
            rc_n    = '0;
`else
            rc_n    = round_Cnt;
`endif
          end
        end
        SOLVED: begin
          rc_n     = RW'(NUM_ROUNDS);
          solved_n = 1'b1;
          disp_n   = 1'b0;
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_puzzle_gauntlet.sv
// Scoreboard bench for puzzle_gauntlet (NUM_ROUNDS=4, SW_W=4, TIMEOUT_TICKS=3).
module tb_puzzle_gauntlet;

  logic       clk = 1'b0;
  logic       rst, alm_Sound, btn_Confirm, tick_1Hz;
  logic [3:0] sw;
  logic       ext_Disp_On, fail_Pulse, puzzle_Solved;
  logic [3:0] hex_Num;
  logic [2:0] round_Cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0] rc;
    logic       fail;
    logic       solved;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  logic [3:0] exp_hex;
  logic [15:0] m_lfsr, m_prev;

  puzzle_gauntlet #(
    .NUM_ROUNDS(4),
    .SW_W(4),
    .TIMEOUT_TICKS(3),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .alm_Sound(alm_Sound),
    .sw(sw),
    .btn_Confirm(btn_Confirm),
    .tick_1Hz(tick_1Hz),
    .ext_Disp_On(ext_Disp_On),
    .hex_Num(hex_Num),
    .round_Cnt(round_Cnt),
    .fail_Pulse(fail_Pulse),
    .puzzle_Solved(puzzle_Solved)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic fb;
    fb = v[0];
    v  = v >> 1;
    if (fb) v = v ^ 16'hB400;
    return v;
  endfunction

  // Reference LFSR; valid while no session has reached SOLVED since reset.
  // m_prev is the value the DUT sees during the cycle before the last edge.
  always @(posedge clk) begin
    if (rst) begin
      m_lfsr <= 16'hACE1;
      m_prev <= 16'hACE1;
    end else if (alm_Sound) begin
      m_prev <= m_lfsr;
      m_lfsr <= lfsr_step(m_lfsr);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; alm_Sound = 1'b0; btn_Confirm = 1'b0; tick_1Hz = 1'b0; sw = '0;
    sb.delete();
    step(); step();
    rst = 1'b0;
  endtask

  task automatic enter_wait();
    alm_Sound = 1'b1;
    step(); step();
  endtask

  task automatic press(input logic [3:0] v, input exp_t ex);
    sw = v; btn_Confirm = 1'b1;
    sb.push_back(ex);
    step();
    btn_Confirm = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (20) step();
    checks++; if (ext_Disp_On !== 1'b0) begin errors++; $display("FAIL reset_disp: got %b want 0", ext_Disp_On); end
    checks++; if (hex_Num !== 4'h0) begin errors++; $display("FAIL reset_hex: got %h want 0", hex_Num); end
    checks++; if (round_Cnt !== 3'd0) begin errors++; $display("FAIL reset_rc: got %0d want 0", round_Cnt); end
    checks++; if (fail_Pulse !== 1'b0) begin errors++; $display("FAIL reset_fail: got %b want 0", fail_Pulse); end
    checks++; if (puzzle_Solved !== 1'b0) begin errors++; $display("FAIL reset_solved: got %b want 0", puzzle_Solved); end
    alm_Sound = 1'b1;
    step();
    checks++; if (ext_Disp_On !== 1'b0) begin errors++; $display("FAIL load_disp: got %b want 0", ext_Disp_On); end
    step();
    checks++; if (ext_Disp_On !== 1'b1) begin errors++; $display("FAIL wait_disp: got %b want 1", ext_Disp_On); end
    exp_hex = lfsr_step(16'hACE1) & 16'h000F;
    checks++; if (hex_Num !== exp_hex) begin errors++; $display("FAIL first_target: got %h want %h", hex_Num, exp_hex); end
  endtask

  task automatic test_solve();
    do_reset();
    enter_wait();
    exp_hex = m_prev[3:0];
    checks++; if (hex_Num !== exp_hex) begin errors++; $display("FAIL solve_t0: got %h want %h", hex_Num, exp_hex); end
    for (int unsigned r = 1; r <= 4; r++) begin
      press(exp_hex, '{rc: 3'(r), fail: 1'b0, solved: (r == 4)});
      e = sb.pop_front();
      checks++;
      if (round_Cnt !== e.rc || fail_Pulse !== e.fail || puzzle_Solved !== e.solved) begin
        errors++;
        $display("FAIL solve_round%0d: got rc=%0d f=%b s=%b want rc=%0d f=%b s=%b",
                 r, round_Cnt, fail_Pulse, puzzle_Solved, e.rc, e.fail, e.solved);
      end
      if (r < 4) begin
        step();
        exp_hex = m_prev[3:0];
        checks++; if (hex_Num !== exp_hex) begin errors++; $display("FAIL solve_target%0d: got %h want %h", r, hex_Num, exp_hex); end
      end
    end
    repeat (5) step();
    checks++; if (puzzle_Solved !== 1'b1 || ext_Disp_On !== 1'b0 || round_Cnt !== 3'd4) begin
      errors++; $display("FAIL solved_hold: got s=%b d=%b rc=%0d want s=1 d=0 rc=4", puzzle_Solved, ext_Disp_On, round_Cnt); end
    alm_Sound = 1'b0;
    step();
    checks++; if (puzzle_Solved !== 1'b0 || round_Cnt !== 3'd0) begin
      errors++; $display("FAIL solved_clear: got s=%b rc=%0d want s=0 rc=0", puzzle_Solved, round_Cnt); end
  endtask

  task automatic test_strike();
    do_reset();
    enter_wait();
    exp_hex = m_prev[3:0];
    for (int unsigned r = 1; r <= 2; r++) begin
      press(exp_hex, '{rc: 3'(r), fail: 1'b0, solved: 1'b0});
      e = sb.pop_front();
      checks++; if (round_Cnt !== e.rc || fail_Pulse !== e.fail) begin
        errors++; $display("FAIL strike_pre%0d: got rc=%0d f=%b want rc=%0d f=%b", r, round_Cnt, fail_Pulse, e.rc, e.fail); end
      step();
      exp_hex = m_prev[3:0];
    end
`ifdef PUZZLE_STRIKE_RESET_EN
    press(~exp_hex, '{rc: 3'd0, fail: 1'b1, solved: 1'b0});
`else
    press(~exp_hex, '{rc: 3'd2, fail: 1'b1, solved: 1'b0});
`endif
    e = sb.pop_front();
    checks++; if (round_Cnt !== e.rc || fail_Pulse !== e.fail || puzzle_Solved !== e.solved) begin
      errors++; $display("FAIL strike_wrong: got rc=%0d f=%b s=%b want rc=%0d f=%b s=%b",
                         round_Cnt, fail_Pulse, puzzle_Solved, e.rc, e.fail, e.solved); end
    step();
    checks++; if (fail_Pulse !== 1'b0) begin errors++; $display("FAIL strike_pulse_len: got %b want 0", fail_Pulse); end
    exp_hex = m_prev[3:0];
    checks++; if (hex_Num !== exp_hex) begin errors++; $display("FAIL strike_redraw: got %h want %h", hex_Num, exp_hex); end
  endtask

  task automatic test_timeout();
    do_reset();
    enter_wait();
    for (int unsigned t = 1; t <= 2; t++) begin
      tick_1Hz = 1'b1; step(); tick_1Hz = 1'b0; step();
      checks++; if (fail_Pulse !== 1'b0) begin errors++; $display("FAIL timeout_early%0d: got %b want 0", t, fail_Pulse); end
    end
    tick_1Hz = 1'b1;
    sb.push_back('{rc: 3'd0, fail: 1'b1, solved: 1'b0});
    step();
    e = sb.pop_front();
    checks++; if (fail_Pulse !== e.fail || round_Cnt !== e.rc) begin
      errors++; $display("FAIL timeout_third: got f=%b rc=%0d want f=%b rc=%0d", fail_Pulse, round_Cnt, e.fail, e.rc); end
    // tick left high through the LOAD cycle: must not count toward the next round
    step();
    tick_1Hz = 1'b0;
    exp_hex = m_prev[3:0];
    checks++; if (hex_Num !== exp_hex) begin errors++; $display("FAIL timeout_redraw: got %h want %h", hex_Num, exp_hex); end
    for (int unsigned t = 1; t <= 2; t++) begin
      tick_1Hz = 1'b1; step(); tick_1Hz = 1'b0; step();
      checks++; if (fail_Pulse !== 1'b0) begin errors++; $display("FAIL timeout_loadtick%0d: got %b want 0", t, fail_Pulse); end
    end
    tick_1Hz = 1'b1;
    press(exp_hex, '{rc: 3'd1, fail: 1'b0, solved: 1'b0});
    tick_1Hz = 1'b0;
    e = sb.pop_front();
    checks++; if (fail_Pulse !== e.fail || round_Cnt !== e.rc) begin
      errors++; $display("FAIL timeout_coincident: got f=%b rc=%0d want f=%b rc=%0d", fail_Pulse, round_Cnt, e.fail, e.rc); end
  endtask

  task automatic test_hold();
    do_reset();
    enter_wait();
    exp_hex = m_prev[3:0];
    sw = exp_hex; btn_Confirm = 1'b1;
    sb.push_back('{rc: 3'd1, fail: 1'b0, solved: 1'b0});
    step();
    e = sb.pop_front();
    checks++; if (round_Cnt !== e.rc) begin errors++; $display("FAIL hold_first: got %0d want %0d", round_Cnt, e.rc); end
    repeat (49) step();
    btn_Confirm = 1'b0;
    step();
    checks++; if (round_Cnt !== 3'd1 || fail_Pulse !== 1'b0) begin
      errors++; $display("FAIL hold_single: got rc=%0d f=%b want rc=1 f=0", round_Cnt, fail_Pulse); end
  endtask

  task automatic test_abort();
    do_reset();
    enter_wait();
    exp_hex = m_prev[3:0];
    for (int unsigned r = 1; r <= 3; r++) begin
      press(exp_hex, '{rc: 3'(r), fail: 1'b0, solved: 1'b0});
      e = sb.pop_front();
      checks++; if (round_Cnt !== e.rc || puzzle_Solved !== e.solved) begin
        errors++; $display("FAIL abort_round%0d: got rc=%0d s=%b want rc=%0d s=%b", r, round_Cnt, puzzle_Solved, e.rc, e.solved); end
      step();
      exp_hex = m_prev[3:0];
    end
    alm_Sound = 1'b0;
    step();
    checks++; if (round_Cnt !== 3'd0 || ext_Disp_On !== 1'b0 || puzzle_Solved !== 1'b0 || hex_Num !== 4'h0) begin
      errors++; $display("FAIL abort_idle: got rc=%0d d=%b s=%b h=%h want all 0", round_Cnt, ext_Disp_On, puzzle_Solved, hex_Num); end
    enter_wait();
    exp_hex = m_prev[3:0];
    press(exp_hex, '{rc: 3'd1, fail: 1'b0, solved: 1'b0});
    e = sb.pop_front();
    checks++; if (round_Cnt !== e.rc) begin errors++; $display("FAIL rst_pre: got %0d want %0d", round_Cnt, e.rc); end
    step();
    rst = 1'b1;
    step();
    checks++; if (round_Cnt !== 3'd0 || ext_Disp_On !== 1'b0 || hex_Num !== 4'h0 || fail_Pulse !== 1'b0 || puzzle_Solved !== 1'b0) begin
      errors++; $display("FAIL rst_mid: got rc=%0d d=%b h=%h f=%b s=%b want all 0",
                         round_Cnt, ext_Disp_On, hex_Num, fail_Pulse, puzzle_Solved); end
    rst = 1'b0; alm_Sound = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_solve();
    test_strike();
    test_timeout();
    test_hold();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
